// File: rtl/mux16_arbiter.sv
// Two-requester valid/ready arbiter feeding one registered 16-bit output channel.
// Bursts lock the grant until last (or MAX_BURST beats); priority alternates between bursts.
module mux16_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [15:0] a_data,
  input  logic        a_last,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [15:0] b_data,
  input  logic        b_last,
  output logic        b_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        out_src,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

  state_t      state, state_nxt;
  logic        prio, prio_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        can_load;
  logic        grant_a, grant_b;
  logic        sel;
  logic [15:0] sel_data;
  logic        sel_last;
  logic        acc;
  logic        release_now;

  // Grant is decided from state, priority and valids only; data never feeds ready.
  always_comb begin
    can_load = !out_valid | out_ready;
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    case (state)
      IDLE: begin
        grant_a = a_valid & (!b_valid | !prio);
        grant_b = b_valid & (!a_valid | prio);
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: ;
    endcase
  end

  assign a_ready  = rst_n & can_load & grant_a;
  assign b_ready  = rst_n & can_load & grant_b;
  assign sel      = grant_b;
  assign sel_data = sel ? b_data : a_data;
  assign sel_last = sel ? b_last : a_last;
  assign acc      = (a_valid & a_ready) | (b_valid & b_ready);

  // cnt is zero in IDLE, so a burst limit of one releases on the very first beat.
  assign release_now = sel_last | (cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    cnt_nxt   = cnt;
    if (acc) begin
      if (release_now) begin
        state_nxt = IDLE;
        prio_nxt  = ~sel;
        cnt_nxt   = 8'd0;
      end else begin
        state_nxt = sel ? LOCK_B : LOCK_A;
        cnt_nxt   = cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_last  <= 1'b0;
      out_src   <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_src   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux16_arbiter.sv
// Bench for mux16_arbiter: two instances (burst limit 4 and 1) share stimulus and are
// compared every cycle against a transaction-level model, plus directed literal checks.
module tb_mux16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_last, b_valid, b_last, out_ready;
  logic [15:0] a_data, b_data;

  logic        r4_a_ready, r4_b_ready, r4_out_valid, r4_out_last, r4_out_src, r4_busy;
  logic [15:0] r4_out_data;
  logic        r1_a_ready, r1_b_ready, r1_out_valid, r1_out_last, r1_out_src, r1_busy;
  logic [15:0] r1_out_data;

  int checks = 0;
  int errors = 0;
  logic last_ar4, last_br4;

  typedef struct {
    int          owner;
    int          prio;
    int          beats;
    logic        ov;
    logic [15:0] od;
    logic        ol;
    logic        os;
  } mstate_t;

  mstate_t m4, m1;

  always #5 clk = ~clk;

  mux16_arbiter #(.MAX_BURST(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(r4_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(r4_b_ready),
    .out_valid(r4_out_valid), .out_data(r4_out_data), .out_last(r4_out_last),
    .out_src(r4_out_src), .out_ready(out_ready), .busy(r4_busy)
  );

  mux16_arbiter #(.MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(r1_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(r1_b_ready),
    .out_valid(r1_out_valid), .out_data(r1_out_data), .out_last(r1_out_last),
    .out_src(r1_out_src), .out_ready(out_ready), .busy(r1_busy)
  );

  function automatic mstate_t mReset();
    mstate_t s;
    s.owner = -1;
    s.prio  = 0;
    s.beats = 0;
    s.ov    = 1'b0;
    s.od    = 16'h0000;
    s.ol    = 1'b0;
    s.os    = 1'b0;
    return s;
  endfunction

  // Returns {a_ready, b_ready}: the lock owner, else the sole or preferred requester, gets room.
  function automatic logic [1:0] mReady(mstate_t s, logic av, logic bv, logic ordy, logic rn);
    int who;
    logic room;
    if (!rn) return 2'b00;
    room = !s.ov || ordy;
    if (s.owner >= 0)  who = s.owner;
    else if (av && bv) who = s.prio;
    else if (av)       who = 0;
    else if (bv)       who = 1;
    else               who = -1;
    return {room && (who == 0), room && (who == 1)};
  endfunction

  function automatic mstate_t mStep(mstate_t s, int mb);
    logic [1:0] r;
    logic acc_a, acc_b;
    int src;
    r = mReady(s, a_valid, b_valid, out_ready, rst_n);
    acc_a = a_valid && r[1];
    acc_b = b_valid && r[0];
    if (acc_a || acc_b) begin
      src   = acc_b ? 1 : 0;
      s.ov  = 1'b1;
      s.od  = acc_b ? b_data : a_data;
      s.ol  = acc_b ? b_last : a_last;
      s.os  = acc_b;
      s.beats = (s.owner < 0) ? 1 : s.beats + 1;
      if (s.ol || s.beats >= mb) begin
        s.owner = -1;
        s.prio  = 1 - src;
        s.beats = 0;
      end else begin
        s.owner = src;
      end
    end else if (out_ready) begin
      s.ov = 1'b0;
    end
    return s;
  endfunction

  task automatic checkVal(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkDut(string tag, mstate_t m, logic ar, logic br, logic ov,
                          logic [15:0] od, logic ol, logic os, logic bz);
    logic [1:0] er;
    er = mReady(m, a_valid, b_valid, out_ready, rst_n);
    checkVal({tag, "_a_ready"},   16'(ar), 16'(er[1]));
    checkVal({tag, "_b_ready"},   16'(br), 16'(er[0]));
    checkVal({tag, "_out_valid"}, 16'(ov), 16'(m.ov));
    checkVal({tag, "_out_data"},  od,      m.od);
    checkVal({tag, "_out_last"},  16'(ol), 16'(m.ol));
    checkVal({tag, "_out_src"},   16'(os), 16'(m.os));
    checkVal({tag, "_busy"},      16'(bz), 16'(m.owner >= 0));
  endtask

  task automatic checkOutput();
    checkDut("mb4", m4, r4_a_ready, r4_b_ready, r4_out_valid, r4_out_data,
             r4_out_last, r4_out_src, r4_busy);
    checkDut("mb1", m1, r1_a_ready, r1_b_ready, r1_out_valid, r1_out_data,
             r1_out_last, r1_out_src, r1_busy);
  endtask

  // One cycle: drive after the falling edge, compare, then advance the model on the rising edge.
  task automatic applyStimulus(logic av, logic [15:0] ad, logic al,
                               logic bv, logic [15:0] bd, logic bl, logic ordy);
    @(negedge clk);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl;
    out_ready = ordy;
    #1;
    checkOutput();
    last_ar4 = r4_a_ready;
    last_br4 = r4_b_ready;
    @(posedge clk);
    m4 = mStep(m4, 4);
    m1 = mStep(m1, 1);
    #1;
  endtask

  task automatic pulseReset(logic pinned);
    @(negedge clk);
    a_valid = 1'b1;
    b_valid = 1'b1;
    rst_n   = 1'b0;
    m4 = mReset();
    m1 = mReset();
    #1;
    checkOutput();
    if (pinned) begin
      checkVal("r031_out_valid", 16'(r4_out_valid), 16'h0);
      checkVal("r031_busy",      16'(r4_busy),      16'h0);
      checkVal("r031_a_ready",   16'(r4_a_ready),   16'h0);
      checkVal("r031_b_ready",   16'(r4_b_ready),   16'h0);
      checkVal("r031_out_data",  r4_out_data,       16'h0000);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] k;
    logic [2:0]  exp_src029 [7];
    rst_n = 1'b0;
    a_valid = 1'b1; a_data = 16'h0; a_last = 1'b0;
    b_valid = 1'b1; b_data = 16'h0; b_last = 1'b0;
    out_ready = 1'b1;
    m4 = mReset();
    m1 = mReset();
    #12;
    checkOutput();
    checkVal("reset_a_ready", 16'(r4_a_ready), 16'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Alternating single-beat transfers from both sides.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 16'h1111, 1, 1, 16'h2222, 1, 1);
      checkVal("r027_data", r4_out_data, (i % 2 == 0) ? 16'h1111 : 16'h2222);
      checkVal("r027_src",  16'(r4_out_src), 16'(i % 2));
    end

    // Three-beat A burst holds B off.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 16'hA000 + 16'(i), (i == 2), 1, 16'h2222, 1, 1);
      checkVal("r028_b_ready", 16'(last_br4), 16'h0);
      checkVal("r028_a_ready", 16'(last_ar4), 16'h1);
      checkVal("r028_data", r4_out_data, 16'hA000 + 16'(i));
      checkVal("r028_src",  16'(r4_out_src), 16'h0);
    end
    applyStimulus(0, 16'h0, 0, 1, 16'h2222, 1, 1);
    checkVal("r028_b_data", r4_out_data, 16'h2222);
    checkVal("r028_b_src",  16'(r4_out_src), 16'h1);

    // Forced release after four beats, B slips in, A resumes.
    exp_src029 = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    k = 16'h0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1, 16'hC000 + k, 0, 1, 16'h2222, 1, 1);
      if (last_ar4) k = k + 16'h1;
      checkVal("r029_src", 16'(r4_out_src), 16'(exp_src029[i]));
      if (i == 3) checkVal("r029_last_kept", 16'(r4_out_last), 16'h0);
      if (i == 4) checkVal("r029_b_data", r4_out_data, 16'h2222);
    end
    applyStimulus(1, 16'hC000 + k, 1, 0, 16'h0, 0, 1);
    checkVal("r029_end_data", r4_out_data, 16'hC006);
    checkVal("r029_end_last", 16'(r4_out_last), 16'h1);

    // Output stall: nobody is ready and the registered beat is held.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 16'h5555, 1, 0, 16'h0, 0, 0);
      checkVal("r030_a_ready", 16'(last_ar4), 16'h0);
      checkVal("r030_b_ready", 16'(last_br4), 16'h0);
      checkVal("r030_hold", r4_out_data, 16'hC006);
    end
    applyStimulus(1, 16'h5555, 1, 0, 16'h0, 0, 1);
    checkVal("r030_resume", r4_out_data, 16'h5555);
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 0, 1);
    checkVal("r030_drain", 16'(r4_out_valid), 16'h0);

    // Reset in the middle of a B lock, then A wins first.
    applyStimulus(0, 16'h0, 0, 1, 16'hB000, 0, 1);
    applyStimulus(1, 16'h7777, 0, 1, 16'hB001, 0, 1);
    checkVal("r031_locked_a_ready", 16'(last_ar4), 16'h0);
    checkVal("r031_busy_before", 16'(r4_busy), 16'h1);
    pulseReset(1);
    applyStimulus(1, 16'h1111, 1, 1, 16'h2222, 1, 1);
    checkVal("r031_first_src", 16'(r4_out_src), 16'h0);
    checkVal("r031_first_data", r4_out_data, 16'h1111);

    // Lone B in IDLE is granted immediately and priority returns to A.
    applyStimulus(0, 16'h0, 0, 1, 16'h2222, 1, 1);
    applyStimulus(0, 16'h0, 0, 1, 16'h3333, 1, 1);
    checkVal("r032_b_ready", 16'(last_br4), 16'h1);
    checkVal("r032_src",  16'(r4_out_src), 16'h1);
    checkVal("r032_data", r4_out_data, 16'h3333);
    applyStimulus(1, 16'h1111, 1, 1, 16'h2222, 1, 1);
    checkVal("r032_prio", 16'(r4_out_src), 16'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        pulseReset(0);
      end else begin
        applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), 16'($urandom), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux16_arbiter.md
MUX16_ARBITER -- requirements
Module: mux16_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16, giving the maximum accepted beats per locked burst, legal range 1..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports a_valid in 1, a_data in 16, a_last in 1 and a_ready out 1, forming requester A's valid/ready channel.
REQ-005 SHALL have ports b_valid in 1, b_data in 16, b_last in 1 and b_ready out 1, forming requester B's valid/ready channel.
REQ-006 SHALL have ports out_valid out 1, out_data out 16, out_last out 1, out_src out 1 (0=A, 1=B) and out_ready in 1, forming the shared output channel.
REQ-007 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-008 SHALL select the 16-bit data path between a_data and b_data with a single 2:1 16-bit mux driven by the internal grant.
REQ-009 SHALL hold one output register (out_valid/out_data/out_last/out_src); can_load = !out_valid | out_ready.
REQ-010 SHALL count a beat as accepted on x when x_valid & x_ready at a rising edge; an accepted beat appears on the output at the next edge (latency 1), with throughput of 1 beat per cycle.
REQ-011 SHALL clear out_valid at an edge where out_valid & out_ready and no beat is accepted.
REQ-012 SHALL implement states IDLE, LOCK_A and LOCK_B, plus a priority pointer prio (0=A first) and an 8-bit beat counter cnt.
REQ-013 In IDLE, the winner SHALL be the only valid requester, or prio's requester if both are valid; winner_ready = can_load, and the loser's ready = 0.
REQ-014 IDLE SHALL transition on a winner beat accepted with last=0 to LOCK_winner with cnt=1.
REQ-015 IDLE SHALL stay IDLE on a winner beat accepted with last=1, setting prio to the non-winner.
REQ-016 In LOCK_x, x_ready SHALL be can_load and the other ready SHALL be 0, regardless of the other's valid.
REQ-017 LOCK_x SHALL return to IDLE with prio = other and cnt = 0 on an accepted beat with last=1.
REQ-018 LOCK_x SHALL also return to IDLE with prio = other and cnt = 0 on the accepted beat that makes cnt reach MAX_BURST (forced release); out_last SHALL carry the input's last unchanged.
REQ-019 LOCK_x SHALL otherwise increment cnt on each accepted beat; with no accepted beat, state and cnt are held.
REQ-020 SHALL set out_src to the source of the registered beat.
REQ-021 With MAX_BURST=1, every accepted beat SHALL return to IDLE and alternate priority.
REQ-022 A requester deasserting valid mid-lock SHALL keep the lock (no timeout).
REQ-023 Ready outputs SHALL be combinational from state, prio, valids, out_valid and out_ready, and SHALL NOT depend on x_data.

Reset
REQ-024 While rst_n=0 (asynchronously): state=IDLE, prio=0, cnt=0, out_valid=0, out_data=16'h0000, out_last=0, out_src=0, busy=0, a_ready=0, b_ready=0.
REQ-025 Reset asserted mid-burst SHALL discard the burst and the registered beat; after release, arbitration restarts from IDLE with A priority.
REQ-026 Deassertion of rst_n SHALL take effect so that the first edge after release may accept a beat.

Verification
REQ-027 Both valid, a_data=16'h1111 last=1, b_data=16'h2222 last=1, out_ready=1 -> outputs 1111(src0), 2222(src1), 1111, 2222 alternating on consecutive cycles.
REQ-028 A burst 0xA000..0xA002 (last on 3rd) with b_valid=1 throughout -> b_ready=0 for 3 accept cycles, outputs A000,A001,A002 src0, then B data next.
REQ-029 MAX_BURST=4, A streams 6 beats without last, B valid -> after 4 A beats the lock releases, a B beat is granted, then A resumes.
REQ-030 out_ready=0 while out_valid=1 -> a_ready=b_ready=0, out_data stable; raising out_ready resumes with no lost or duplicated beat.
REQ-031 rst_n pulsed low during LOCK_B mid-burst -> out_valid=0 and busy=0 immediately; after release with both valid, A wins first.
REQ-032 Only b_valid=1 in IDLE with prio=0 -> B granted at once (no idle cycle); then prio=0.
